// File: rtl/signal_maker_pkg.sv
// Shared definitions for the signal maker loop: default word width, reference
// pattern, capture FSM encoding and counter sizing helper.
package signal_maker_pkg;

    localparam int SM_W = 6;
    localparam logic [SM_W-1:0] SM_PATTERN = 6'b100111;

    // Counter must reach W (not just W-1) when the parity bit is pending.
    localparam int CNT_W = $clog2(SM_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } sm_state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/signal_capture_shreg.sv
// Shift register and bit counter for the capture stage; bits enter at the LSB.
module signal_capture_shreg
    import signal_maker_pkg::*;
#(
    parameter int DEPTH = SM_W - 1,
    parameter int CW    = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en_i,
    input  logic             clear_i,
    input  logic             bit_i,
    output logic [DEPTH-1:0] word_o,
    output logic [CW-1:0]    cnt_o
);

    logic [DEPTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Clear has priority: a completing or abandoned word never leaves residue.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d  = {sr_q[DEPTH-2:0], bit_i};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign word_o = sr_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/signal_capture_sipo.sv
// Serial-to-parallel capture of the signal maker stream with pattern match and
// framing check. Define SIG_CAPTURE_PARITY_EN to add a trailing even-parity bit.
module signal_capture_sipo
    import signal_maker_pkg::*;
#(
    parameter int             W       = SM_W,
    parameter logic [W-1:0]   PATTERN = W'(SM_PATTERN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sin,
    input  logic          sin_valid,
    output logic [W-1:0]  dout,
    output logic          dout_valid,
    output logic          match,
    output logic          busy,
    output logic          frame_err,
    output logic          parity_err,
    output sm_state_e     dbg_state
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_DATA = CW'(W - 1);

    // Without parity the final data bit is consumed live, so only W-1 bits are stored.
`ifdef SIG_CAPTURE_PARITY_EN
    localparam int DEPTH = W;
`else
    localparam int DEPTH = W - 1;
`endif

    sm_state_e        state_q;
    logic [W-1:0]     dout_q;
    logic             dout_valid_q;
    logic             match_q;
    logic             busy_q;
    logic             frame_err_q;

    logic [DEPTH-1:0] sr_word;
    logic [CW-1:0]    cnt;
    logic             last_data;
    logic             complete;
    logic             abort;
    logic             shift_en;
    logic             clear;
    logic [W-1:0]     word_done;
    logic             perr_done;

    always_comb begin
        last_data = (cnt == LAST_DATA);
`ifdef SIG_CAPTURE_PARITY_EN
        complete  = sin_valid && (state_q == ST_PAR);
        word_done = sr_word;
        perr_done = ^{sr_word, sin};
`else
        complete  = sin_valid && last_data;
        word_done = {sr_word, sin};
        perr_done = 1'b0;
`endif
        abort    = !sin_valid && (state_q != ST_IDLE);
        shift_en = sin_valid && !complete;
        clear    = complete || abort;
    end

    signal_capture_shreg #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .clear_i    (clear),
        .bit_i      (sin),
        .word_o     (sr_word),
        .cnt_o      (cnt)
    );

    // busy tracks the state being entered so it lines up with the registered counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            match_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dout_valid_q <= complete;
            frame_err_q  <= abort;
            if (complete) begin
                dout_q  <= word_done;
                match_q <= (word_done == PATTERN) && !perr_done;
            end
            case (state_q)
                ST_IDLE: begin
                    state_q <= sin_valid ? ST_SHIFT : ST_IDLE;
                    busy_q  <= sin_valid;
                end
                ST_SHIFT: begin
                    if (!sin_valid) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_data) begin
`ifdef SIG_CAPTURE_PARITY_EN
                        state_q <= ST_PAR;
                        busy_q  <= 1'b1;
`else
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIG_CAPTURE_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else if (complete) begin
            parity_err_q <= perr_done;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign match      = match_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;

endmodule
